// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory stage.
//   REGISTER_LEN     - datapath width (ALU result, store data, load data)
//   REG_ADDRESS_LEN  - register-file index width
//   DATA_MEM_BASE    - byte address mapped to data memory word 0
//   DATA_MEM_DEPTH   - data memory size in 32-bit words
//   WCNT_W           - wait counter width (wait cycles 0..15)
//   mem_state_e      - access state, decoded alongside the wait counter
package mem_stage_pkg;
  localparam int REGISTER_LEN    = 32;
  localparam int REG_ADDRESS_LEN = 4;
  localparam int DATA_MEM_BASE   = 1024;
  localparam int DATA_MEM_DEPTH  = 64;
  localparam int WCNT_W          = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,  // no memory op registered
    ST_WAIT  = 2'd1,  // memory op registered, wait count still running
    ST_READY = 2'd2   // memory op registered, access completes this cycle
  } mem_state_e;

  function automatic logic is_mem_op(input logic r_en, input logic w_en);
    return r_en | w_en;
  endfunction
endpackage

// File: rtl/data_memory.sv
// Word-addressed data memory with asynchronous read and synchronous write.
// Ports:
//   clk      - rising-edge clock (write port)
//   addr     - byte address; bits [1:0] ignored, BASE_ADDR maps to word 0
//   wr_req   - write request; only honoured when addr is in range
//   wr_data  - store data
//   rd_data  - contents of the addressed word (combinational)
//   in_range - addr falls inside [BASE_ADDR, BASE_ADDR + 4*DEPTH)
// The array has no reset; contents survive a pipeline reset.
module data_memory
  import mem_stage_pkg::*;
#(
  parameter int DEPTH     = DATA_MEM_DEPTH,
  parameter int BASE_ADDR = DATA_MEM_BASE
) (
  input  logic                    clk,
  input  logic [REGISTER_LEN-1:0] addr,
  input  logic                    wr_req,
  input  logic [REGISTER_LEN-1:0] wr_data,
  output logic [REGISTER_LEN-1:0] rd_data,
  output logic                    in_range
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [REGISTER_LEN-1:0] BASE = REGISTER_LEN'(BASE_ADDR);
  localparam logic [REGISTER_LEN-1:0] SPAN = REGISTER_LEN'(4 * DEPTH);

  logic [REGISTER_LEN-1:0] mem [DEPTH];
  logic [REGISTER_LEN-1:0] offset;
  logic [IDX_W-1:0]        idx;

  // The subtraction wraps for addresses below BASE; the explicit >= test
  // rejects those before the span test is trusted.
  assign offset   = addr - BASE;
  assign idx      = offset[IDX_W+1:2];
  assign in_range = (addr >= BASE) && (offset < SPAN);
  assign rd_data  = mem[idx];

  always_ff @(posedge clk) begin
    if (wr_req && in_range) begin
      mem[idx] <= wr_data;
    end
  end
endmodule

// File: rtl/mem_stage.sv
// Memory stage: EX/MEM pipeline register, data memory and a wait-state
// controller modelling a slow SRAM.
// Ports:
//   clk, rst           - clock, asynchronous active-low reset
//   *_in               - operation from EX stage, captured when not frozen
//   wb_en_out          - write-back enable, suppressed while frozen
//   mem_r_en_out       - selects mem_data_out at write-back
//   dest_out           - registered destination register
//   alu_res_out        - registered ALU result / effective address
//   mem_data_out       - load data, valid only in the READY cycle of a load
//   mem_freeze         - upstream stages and this capture register must hold
//   addr_err           - registered memory op addresses outside the array
//   dbg_state          - current access state (IDLE / WAIT / READY)
// Handshake: an op is accepted on every rising edge where mem_freeze is 0;
// while mem_freeze is 1 the inputs are ignored and must be held upstream.
// A memory op occupies the stage WAIT_CYCLES+1 cycles, any other op 1 cycle.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int DEPTH       = DATA_MEM_DEPTH,
  parameter int BASE_ADDR   = DATA_MEM_BASE,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wb_en_in,
  input  logic                       mem_r_en_in,
  input  logic                       mem_w_en_in,
  input  logic [REG_ADDRESS_LEN-1:0] dest_in,
  input  logic [REGISTER_LEN-1:0]    alu_res_in,
  input  logic [REGISTER_LEN-1:0]    val_Rm_in,
  output logic                       wb_en_out,
  output logic                       mem_r_en_out,
  output logic [REG_ADDRESS_LEN-1:0] dest_out,
  output logic [REGISTER_LEN-1:0]    alu_res_out,
  output logic [REGISTER_LEN-1:0]    mem_data_out,
  output logic                       mem_freeze,
  output logic                       addr_err,
  output mem_state_e                 dbg_state
);
  logic                       wb_en_q;
  logic                       mem_r_en_q;
  logic                       mem_w_en_q;
  logic [REG_ADDRESS_LEN-1:0] dest_q;
  logic [REGISTER_LEN-1:0]    alu_res_q;
  logic [REGISTER_LEN-1:0]    val_rm_q;
  logic [WCNT_W-1:0]          wcnt;
  mem_state_e                 state;

  logic                    mem_op_q;
  logic                    wr_req;
  logic                    in_range;
  logic [REGISTER_LEN-1:0] rd_data;

  assign mem_op_q   = is_mem_op(mem_r_en_q, mem_w_en_q);
  assign mem_freeze = mem_op_q && (wcnt != '0);

  // The state register tracks the wait counter so it always equals the
  // decode of (mem op registered, wcnt): IDLE / WAIT / READY.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_en_q    <= 1'b0;
      mem_r_en_q <= 1'b0;
      mem_w_en_q <= 1'b0;
      dest_q     <= '0;
      alu_res_q  <= '0;
      val_rm_q   <= '0;
      wcnt       <= '0;
      state      <= ST_IDLE;
    end else if (!mem_freeze) begin
      wb_en_q    <= wb_en_in;
      mem_r_en_q <= mem_r_en_in;
      mem_w_en_q <= mem_w_en_in;
      dest_q     <= dest_in;
      alu_res_q  <= alu_res_in;
      val_rm_q   <= val_Rm_in;
      if (is_mem_op(mem_r_en_in, mem_w_en_in)) begin
        wcnt  <= WCNT_W'(WAIT_CYCLES);
        state <= (WAIT_CYCLES != 0) ? ST_WAIT : ST_READY;
      end else begin
        wcnt  <= '0;
        state <= ST_IDLE;
      end
    end else begin
      wcnt  <= wcnt - 1'b1;
      state <= (wcnt == WCNT_W'(1)) ? ST_READY : ST_WAIT;
    end
  end

  // READY lasts exactly one cycle per op, so a store writes exactly once.
  assign wr_req = (state == ST_READY) && mem_w_en_q;

  data_memory #(
    .DEPTH     (DEPTH),
    .BASE_ADDR (BASE_ADDR)
  ) u_data_memory (
    .clk      (clk),
    .addr     (alu_res_q),
    .wr_req   (wr_req),
    .wr_data  (val_rm_q),
    .rd_data  (rd_data),
    .in_range (in_range)
  );

  assign mem_data_out = (mem_r_en_q && in_range && (state == ST_READY)) ? rd_data : '0;
  assign addr_err     = mem_op_q && !in_range;
  assign wb_en_out    = wb_en_q && !mem_freeze;
  assign mem_r_en_out = mem_r_en_q;
  assign dest_out     = dest_q;
  assign alu_res_out  = alu_res_q;
  assign dbg_state    = state;
endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;
  import mem_stage_pkg::*;

  localparam int MW = 2;  // wait cycles of the main instance

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // main instance (WAIT_CYCLES = 2)
  logic        wb_en_in, mem_r_en_in, mem_w_en_in;
  logic [3:0]  dest_in;
  logic [31:0] alu_res_in, val_rm_in;
  logic        wb_en_out, mem_r_en_out, mem_freeze, addr_err;
  logic [3:0]  dest_out;
  logic [31:0] alu_res_out, mem_data_out;
  mem_state_e  dbg_state;

  // zero-wait instance
  logic        z_wb_en_in, z_mem_r_en_in, z_mem_w_en_in;
  logic [3:0]  z_dest_in;
  logic [31:0] z_alu_res_in, z_val_rm_in;
  logic        z_wb_en_out, z_mem_r_en_out, z_mem_freeze, z_addr_err;
  logic [3:0]  z_dest_out;
  logic [31:0] z_alu_res_out, z_mem_data_out;
  mem_state_e  z_dbg_state;

  mem_stage #(.DEPTH(64), .BASE_ADDR(1024), .WAIT_CYCLES(MW)) dut (
    .clk(clk), .rst(rst),
    .wb_en_in(wb_en_in), .mem_r_en_in(mem_r_en_in), .mem_w_en_in(mem_w_en_in),
    .dest_in(dest_in), .alu_res_in(alu_res_in), .val_Rm_in(val_rm_in),
    .wb_en_out(wb_en_out), .mem_r_en_out(mem_r_en_out), .dest_out(dest_out),
    .alu_res_out(alu_res_out), .mem_data_out(mem_data_out),
    .mem_freeze(mem_freeze), .addr_err(addr_err), .dbg_state(dbg_state)
  );

  mem_stage #(.DEPTH(64), .BASE_ADDR(1024), .WAIT_CYCLES(0)) dut_z (
    .clk(clk), .rst(rst),
    .wb_en_in(z_wb_en_in), .mem_r_en_in(z_mem_r_en_in), .mem_w_en_in(z_mem_w_en_in),
    .dest_in(z_dest_in), .alu_res_in(z_alu_res_in), .val_Rm_in(z_val_rm_in),
    .wb_en_out(z_wb_en_out), .mem_r_en_out(z_mem_r_en_out), .dest_out(z_dest_out),
    .alu_res_out(z_alu_res_out), .mem_data_out(z_mem_data_out),
    .mem_freeze(z_mem_freeze), .addr_err(z_addr_err), .dbg_state(z_dbg_state)
  );

  // ---------------- scoreboard ----------------
  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mdl[64];
  logic [31:0] zmdl[64];

  function automatic logic in_rng(input logic [31:0] a);
    return (a >= 32'd1024) && ((a - 32'd1024) < 32'd256);
  endfunction

  function automatic int widx(input logic [31:0] a);
    logic [31:0] off;
    off = (a - 32'd1024) >> 2;
    return int'(off[5:0]);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_nop();
    wb_en_in = 0; mem_r_en_in = 0; mem_w_en_in = 0;
    dest_in = '0; alu_res_in = '0; val_rm_in = '0;
    z_wb_en_in = 0; z_mem_r_en_in = 0; z_mem_w_en_in = 0;
    z_dest_in = '0; z_alu_res_in = '0; z_val_rm_in = '0;
  endtask

  // Issues one op to the main instance (caller guarantees mem_freeze=0),
  // follows it through its occupancy and returns in its final cycle.
  task automatic run_op(input string tag, input logic r, input logic w, input logic wb,
                        input logic [3:0] d, input logic [31:0] a, input logic [31:0] v);
    int          hold;
    int          exp_hold;
    logic        exp_err;
    logic [31:0] exp_d;
    mem_state_e  exp_st;
    exp_err  = (r | w) && !in_rng(a);
    exp_hold = (r | w) ? MW + 1 : 1;
    exp_st   = (r | w) ? ST_READY : ST_IDLE;
    if (r) exp_q.push_back(in_rng(a) ? mdl[widx(a)] : 32'd0);
    wb_en_in = wb; mem_r_en_in = r; mem_w_en_in = w;
    dest_in = d; alu_res_in = a; val_rm_in = v;
    tick();
    hold = 1;
    while (mem_freeze && hold <= 16) begin
      n_vec++;
      if (wb_en_out !== 1'b0) begin
        n_err++; $display("FAIL %s bubble_wb: got %b want 0", tag, wb_en_out);
      end
      n_vec++;
      if (addr_err !== exp_err) begin
        n_err++; $display("FAIL %s addr_err_wait: got %b want %b", tag, addr_err, exp_err);
      end
      n_vec++;
      if (dbg_state !== ST_WAIT) begin
        n_err++; $display("FAIL %s state_wait: got %0d want %0d", tag, dbg_state, ST_WAIT);
      end
      tick();
      hold++;
    end
    n_vec++;
    if (hold !== exp_hold) begin
      n_err++; $display("FAIL %s hold_cycles: got %0d want %0d", tag, hold, exp_hold);
    end
    n_vec++;
    if (dbg_state !== exp_st) begin
      n_err++; $display("FAIL %s state_final: got %0d want %0d", tag, dbg_state, exp_st);
    end
    n_vec++;
    if (addr_err !== exp_err) begin
      n_err++; $display("FAIL %s addr_err: got %b want %b", tag, addr_err, exp_err);
    end
    n_vec++;
    if (wb_en_out !== wb || dest_out !== d || alu_res_out !== a || mem_r_en_out !== r) begin
      n_err++;
      $display("FAIL %s passthru: got wb=%b dest=%0d alu=%h r=%b want wb=%b dest=%0d alu=%h r=%b",
               tag, wb_en_out, dest_out, alu_res_out, mem_r_en_out, wb, d, a, r);
    end
    exp_d = 32'd0;
    if (r) begin
      if (exp_q.size() == 0) begin
        n_vec++; n_err++; $display("FAIL %s scoreboard_empty: got empty want entry", tag);
      end else begin
        exp_d = exp_q.pop_front();
      end
    end
    n_vec++;
    if (mem_data_out !== exp_d) begin
      n_err++; $display("FAIL %s mem_data: got %h want %h", tag, mem_data_out, exp_d);
    end
    if (w && in_rng(a)) mdl[widx(a)] = v;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    drive_nop();
    rst = 1'b0;
    tick(); tick();
    n_vec++;
    if ({wb_en_out, mem_r_en_out, dest_out, alu_res_out, mem_data_out, mem_freeze, addr_err} !== '0
        || dbg_state !== ST_IDLE) begin
      n_err++; $display("FAIL reset_outputs: got alu=%h data=%h frz=%b want all 0",
                        alu_res_out, mem_data_out, mem_freeze);
    end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_store_load();
    run_op("st1028", 0, 1, 0, 4'd0, 32'd1028, 32'hDEADBEEF);
    run_op("ld1028", 1, 0, 1, 4'd5, 32'd1028, 32'd0);
  endtask

  task automatic test_non_mem();
    run_op("add7", 0, 0, 1, 4'd3, 32'd7, 32'd0);
    run_op("add_max", 0, 0, 1, 4'd15, 32'hFFFF_FFFF, 32'd9);
  endtask

  task automatic test_back_to_back();
    run_op("b2b_st1024", 0, 1, 0, 4'd0, 32'd1024, 32'hA5A5_0001);
    run_op("b2b_st1028", 0, 1, 0, 4'd0, 32'd1028, 32'h5A5A_0002);
    run_op("b2b_ld1024", 1, 0, 1, 4'd1, 32'd1024, 32'd0);
    run_op("b2b_ld1028", 1, 0, 1, 4'd2, 32'd1028, 32'd0);
    run_op("st_last",    0, 1, 0, 4'd0, 32'd1276, 32'h1234_5678);
    run_op("ld_last",    1, 0, 1, 4'd6, 32'd1279, 32'd0);
  endtask

  task automatic test_out_of_range();
    run_op("ld1020", 1, 0, 1, 4'd4, 32'd1020, 32'd0);
    run_op("ld1280", 1, 0, 1, 4'd4, 32'd1280, 32'd0);
    run_op("st1280", 0, 1, 0, 4'd0, 32'd1280, 32'hBAD0_BAD0);
    run_op("ld1024_after", 1, 0, 1, 4'd7, 32'd1024, 32'd0);
  endtask

  task automatic test_reset_mid();
    run_op("pre_st1032", 0, 1, 0, 4'd0, 32'd1032, 32'h1111_1111);
    wb_en_in = 0; mem_r_en_in = 0; mem_w_en_in = 1;
    dest_in = '0; alu_res_in = 32'd1032; val_rm_in = 32'h2222_2222;
    tick();
    n_vec++;
    if (mem_freeze !== 1'b1) begin
      n_err++; $display("FAIL rst_mid_pre_freeze: got %b want 1", mem_freeze);
    end
    #2 rst = 1'b0;
    #1;
    n_vec++;
    if ({wb_en_out, mem_r_en_out, dest_out, alu_res_out, mem_data_out, mem_freeze, addr_err} !== '0
        || dbg_state !== ST_IDLE) begin
      n_err++; $display("FAIL rst_mid_outputs: got alu=%h frz=%b state=%0d want 0",
                        alu_res_out, mem_freeze, dbg_state);
    end
    drive_nop();
    tick(); tick();
    rst = 1'b1;
    tick();
    run_op("post_rst_ld1032", 1, 0, 1, 4'd8, 32'd1032, 32'd0);
  endtask

  task automatic test_wait0();
    logic [31:0] a;
    logic [31:0] v;
    logic [31:0] e;
    drive_nop();
    for (int k = 0; k < 16; k++) begin
      if (k % 2 == 0) begin
        a = 32'd1024 + 32'($urandom_range(0, 63)) * 4;
        v = $urandom();
        z_mem_w_en_in = 1; z_mem_r_en_in = 0; z_wb_en_in = 0;
        z_alu_res_in = a; z_val_rm_in = v; z_dest_in = '0;
        zmdl[widx(a)] = v;
      end else begin
        z_mem_w_en_in = 0; z_mem_r_en_in = 1; z_wb_en_in = 1;
        z_alu_res_in = a; z_val_rm_in = '0; z_dest_in = 4'(k);
        exp_q.push_back(zmdl[widx(a)]);
      end
      tick();
      n_vec++;
      if (z_mem_freeze !== 1'b0 || z_dbg_state !== ST_READY) begin
        n_err++; $display("FAIL w0_freeze_k%0d: got frz=%b state=%0d want 0/%0d",
                          k, z_mem_freeze, z_dbg_state, ST_READY);
      end
      e = 32'd0;
      if (k % 2 == 1) begin
        if (exp_q.size() != 0) e = exp_q.pop_front();
      end
      n_vec++;
      if (z_mem_data_out !== e || z_alu_res_out !== a) begin
        n_err++; $display("FAIL w0_data_k%0d: got data=%h alu=%h want data=%h alu=%h",
                          k, z_mem_data_out, z_alu_res_out, e, a);
      end
    end
    drive_nop();
    tick();
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    drive_nop();
    rst = 1'b0;
    test_reset();
    test_store_load();
    test_non_mem();
    test_back_to_back();
    test_out_of_range();
    test_reset_mid();
    drive_nop();
    tick();
    test_wait0();
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++; $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory stage of the ARM pipeline, directly downstream of EX_Stage.
- Contains the EX/MEM pipeline register, a word-addressed data memory, and a wait-state controller that models a slow SRAM.
- While an access is in progress it raises mem_freeze to the hazard/pipeline-register logic.
- Feeds the MEM/WB register with alu result, memory read data, destination and write-back enable.

Parameters:
- DEPTH, 64, data memory size in 32-bit words; power of two.
- BASE_ADDR, 1024, byte address mapped to word 0.
- WAIT_CYCLES, 2, extra cycles each load/store occupies the stage; 0 to 15.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- wb_en_in  in  1  write-back enable from EX_Stage
- mem_r_en_in  in  1  load
- mem_w_en_in  in  1  store
- dest_in  in  `REG_ADDRESS_LEN  destination register
- alu_res_in  in  `REGISTER_LEN  effective byte address or ALU result
- val_Rm_in  in  `REGISTER_LEN  store data
- wb_en_out  out  1  write-back enable to MEM/WB
- mem_r_en_out  out  1  selects mem_data_out at write-back
- dest_out  out  `REG_ADDRESS_LEN  registered destination
- alu_res_out  out  `REGISTER_LEN  registered ALU result
- mem_data_out  out  `REGISTER_LEN  load data
- mem_freeze  out  1  high = upstream stages and EX/MEM capture must hold
- addr_err  out  1  registered op is a memory op with out-of-range address

Behaviour:
- Reset (rst=0, async): all stage registers 0, wait counter 0, state IDLE.
  - Outputs during reset: wb_en_out=0, mem_r_en_out=0, dest_out=0, alu_res_out=0, mem_data_out=0, mem_freeze=0, addr_err=0.
  - Memory array is not reset.
- Capture: on each posedge with mem_freeze=0, the stage register loads all *_in signals.
  - On the same edge, wcnt loads WAIT_CYCLES if (mem_r_en_in|mem_w_en_in), else 0.
- Freeze: mem_freeze = (mem_r_en_q|mem_w_en_q) && wcnt!=0, combinational.
  - While frozen, the stage register holds and wcnt decrements by 1 each posedge.
  - Hold time: a memory op occupies the stage exactly WAIT_CYCLES+1 cycles. A non-memory op occupies it 1 cycle.
  - WAIT_CYCLES=0: mem_freeze is never asserted.
- States (derived from wcnt):
  - IDLE: no mem op registered.
  - WAIT: mem op registered, wcnt!=0.
  - READY: mem op registered, wcnt==0.
  - Transitions: IDLE/READY -> WAIT on capture of a mem op with WAIT_CYCLES>0. WAIT -> READY when wcnt reaches 0. READY -> IDLE or WAIT on the next capture.
- Address: idx = (alu_res_q - BASE_ADDR) >> 2, truncated to log2(DEPTH) bits. Bits [1:0] are ignored (no alignment fault).
  - in_range = alu_res_q >= BASE_ADDR && (alu_res_q - BASE_ADDR) < 4*DEPTH.
- Store: array[idx] <= val_Rm_q on the posedge where state==READY, mem_w_en_q=1 and in_range. Exactly one write per store.
- Load: mem_data_out = array[idx] (asynchronous read) when mem_r_en_q && in_range && state==READY; otherwise 0.
- addr_err = (mem_r_en_q|mem_w_en_q) && !in_range. It is held for the whole occupancy.
  - Out-of-range store: writes nothing. Out-of-range load: returns 0. Wait timing is unchanged.
- Bubble: wb_en_out = wb_en_q && !mem_freeze, so no write-back happens during WAIT.
  - mem_r_en_out, dest_out, alu_res_out pass the registered values.
- Back-to-back memory ops: the second op is captured on the edge leaving READY and starts a fresh WAIT. No extra idle cycle.
- Reset asserted mid-access: counter and register clear immediately; the pending store is dropped and memory is untouched.
- Store then load to the same address in consecutive ops: the load returns the new data.

Decomposition:
- Shared package/Defines.v: `REGISTER_LEN, `REG_ADDRESS_LEN, plus new `DATA_MEM_BASE (1024) and `DATA_MEM_DEPTH (64), used as parameter defaults.
- One sub-module, data_memory: array, async read, sync write, index/in_range computation.
- Capture register and wait counter stay in mem_stage.

Test Plan:
- Reset: assert rst=0 mid-cycle with a store in WAIT -> all outputs 0 immediately. After release, a load of that address returns the prior contents.
- Store/load, WAIT_CYCLES=2: store alu_res=1028, val_Rm=0xDEADBEEF, then load 1028 with wb_en=1, dest=5.
  - mem_freeze high for 2 cycles on each op; array[1]=0xDEADBEEF.
  - Load READY cycle: mem_data_out=0xDEADBEEF, wb_en_out=1, dest_out=5.
- Non-memory op: ADD with alu_res=7, wb_en=1 -> mem_freeze never asserts; next cycle alu_res_out=7, wb_en_out=1, mem_data_out=0.
- Back-to-back: stores to 1024 and 1028 in consecutive issue slots -> freeze pattern 1,1,0,1,1,0; both words written; no lost op.
- Out-of-range: load from 1020 and from 1024+256 -> addr_err=1 for 3 cycles each, mem_data_out=0. A store to 1280 leaves the array unchanged.
- WAIT_CYCLES=0 build: alternating loads and stores -> mem_freeze stays 0; one op per cycle with correct data.
